// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync/porch/active counters with registered syncs, de, coordinates and frame markers.
// Outputs are one register stage from the counter update; the en=0 input stalls the raster and squelches pulses.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          sol,
  output logic          sof,
  output logic          eof
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SW   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SW   = CW'(V_SYNC);
  localparam logic [CW-1:0] H_AS   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_AE   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_AS   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_AE   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  logic [CW-1:0] h_nxt, v_nxt, x_nxt, y_nxt;
  logic          de_nxt, eof_nxt;

  // Every registered output is decoded from the next position so it lines up with h_cnt/v_cnt.
  always_comb begin
    h_nxt = h_cnt + ONE;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
    end
    de_nxt  = (h_nxt >= H_AS) && (h_nxt < H_AE) && (v_nxt >= V_AS) && (v_nxt < V_AE);
    x_nxt   = de_nxt ? h_nxt - H_AS : '0;
    y_nxt   = de_nxt ? v_nxt - V_AS : '0;
    eof_nxt = de_nxt && (x_nxt == X_LAST) && (y_nxt == Y_LAST);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      x     <= '0;
      y     <= '0;
      de    <= 1'b0;
      hsync <= HS_POL;
      vsync <= VS_POL;
      sol   <= 1'b0;
      sof   <= 1'b0;
      eof   <= 1'b0;
    end else if (en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      de    <= de_nxt;
      hsync <= (h_nxt < H_SW) ? HS_POL : ~HS_POL;
      vsync <= (v_nxt < V_SW) ? VS_POL : ~VS_POL;
      sol   <= (h_nxt == '0);
      sof   <= (h_nxt == '0) && (v_nxt == '0);
      eof   <= eof_nxt;
    end else begin
      // Stalled: positional outputs hold, markers drop so they never repeat.
      sol <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-002 SHALL provide parameter H_BP, default 48, horizontal back porch.
REQ-003 SHALL provide parameter H_ACTIVE, default 640, horizontal active pixels.
REQ-004 SHALL provide parameter H_FP, default 16, horizontal front porch.
REQ-005 SHALL provide parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 SHALL provide parameter V_BP, default 33, vertical back porch.
REQ-007 SHALL provide parameter V_ACTIVE, default 480, vertical active lines.
REQ-008 SHALL provide parameter V_FP, default 10, vertical front porch.
REQ-009 SHALL provide parameter HS_POL, default 0, hsync level during the sync region (0 = active-low).
REQ-010 SHALL provide parameter VS_POL, default 0, vsync level during the sync region.
REQ-011 SHALL provide parameter CW, default 12, width of all counter and coordinate outputs.
REQ-012 SHALL have ports:
- vga_clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel advance enable
- h_cnt  out  CW  horizontal position, 0..H_TOTAL-1
- v_cnt  out  CW  vertical position, 0..V_TOTAL-1
- x  out  CW  active-area column
- y  out  CW  active-area row
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  display enable
- sol  out  1  start-of-line pulse
- sof  out  1  start-of-frame pulse
- eof  out  1  last active pixel of frame

Function
REQ-013 SHALL define H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise; line order is sync, back porch, active, front porch.
REQ-014 SHALL advance counters only on a rising edge with en=1; with en=0, all counters and level outputs hold their values.
REQ-015 SHALL increment h_cnt; at H_TOTAL-1 it wraps to 0 and v_cnt increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
REQ-016 SHALL drive every output from a register, aligned with the h_cnt/v_cnt value presented in the same cycle, with no combinational path from en or rst to any output.
REQ-017 SHALL drive hsync = HS_POL when h_cnt < H_SYNC, else ~HS_POL; vsync uses v_cnt, V_SYNC and VS_POL in the same way.
REQ-018 SHALL assert de when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
REQ-019 SHALL output x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) while de=1, and x=0, y=0 while de=0.
REQ-020 SHALL pulse sol high for exactly one cycle, only in the cycle following an advance into h_cnt=0.
REQ-021 SHALL pulse sof for one cycle, only following an advance into (0,0); sof implies sol.
REQ-022 SHALL pulse eof for one cycle, only following an advance into x=H_ACTIVE-1, y=V_ACTIVE-1.
REQ-023 SHALL hold sol, sof and eof low during every cycle that follows an en=0 edge, so that pulses never repeat during a stall.
REQ-024 SHALL compute all arithmetic at CW bits; CW must satisfy 2^CW >= max(H_TOTAL, V_TOTAL), and other values are unsupported.

Reset
REQ-025 SHALL, on rst=1 at an edge, set h_cnt=0, v_cnt=0, x=0, y=0, de=0, hsync=HS_POL, vsync=VS_POL, sol=0, sof=0, eof=0.
REQ-026 SHALL give rst priority over en, including a reset asserted mid-line or mid-frame.
REQ-027 SHALL NOT emit sol or sof for the reset position itself; the first sof occurs after the first frame wrap.

Verification
REQ-028 Defaults, en=1 constantly, after rst -> hsync low for h_cnt 0..95; de first high at h_cnt=144, v_cnt=35 with x=0, y=0; last de at h_cnt=783, v_cnt=514; eof at that same cycle.
REQ-029 Full frame, en=1 -> exactly 420000 cycles between consecutive sof pulses; 800 cycles between sol pulses; 480 lines with de per frame.
REQ-030 en toggling 1,0,1,0 -> counters advance every other edge; a sol issued before a stall is not repeated while en=0; frame period is 840000 cycles.
REQ-031 rst pulsed at h_cnt=500, v_cnt=200 -> next cycle h_cnt=0, v_cnt=0, de=0, hsync=0, vsync=0, sof=0.
REQ-032 HS_POL=1, VS_POL=1, H=4/2/8/2, V=1/1/4/1 -> hsync high for h_cnt 0..3; H_TOTAL=16; V_TOTAL=7; de for h_cnt 6..13 on v_cnt 2..5; sof every 112 cycles.
